// File: rtl/core_pkg.sv
// Shared definitions for the execute-stage units: M-extension funct3 codes
// and the divider state encoding.
package core_pkg;

    localparam logic [2:0] DIV_F3  = 3'b100;
    localparam logic [2:0] DIVU_F3 = 3'b101;
    localparam logic [2:0] REM_F3  = 3'b110;
    localparam logic [2:0] REMU_F3 = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIN  = ST_FIN
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, emit one quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    // The compare is done at full XLEN+1 width; the kept difference always
    // fits in XLEN bits because the partial remainder stays below the divisor.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        fits    = (shifted >= {1'b0, divisor});
        diff    = shifted[XLEN-1:0] - divisor;
        if (fits) begin
            rem_out = diff;
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one restoring step per cycle,
// Busy while iterating, single-cycle Done pulse with a registered Result.
module div_unit
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [XLEN-1:0] Rs1,
    input  logic [XLEN-1:0] Rs2,
    input  logic [2:0]      Funct3,
    output logic [XLEN-1:0] Result,
    output logic            Busy,
    output logic            Done
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state, next_state;

    logic [XLEN-1:0]  dividend_q;
    logic [XLEN-1:0]  divisor_q;
    logic [XLEN-1:0]  rem_q;
    logic [CNT_W-1:0] count_q;
    logic             q_sign_q;
    logic             r_sign_q;
    logic             is_rem_q;
    logic             is_signed_q;

    logic             accept;
    logic             req_signed;
    logic             div_zero;
    logic             overflow;
    logic             last_step;
    logic [XLEN-1:0]  abs_rs1;
    logic [XLEN-1:0]  abs_rs2;
    logic [XLEN-1:0]  special_result;
    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    logic [XLEN-1:0]  final_result;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .quo_in  (dividend_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Request decode; the special cases bypass iteration entirely.
    always_comb begin
        accept     = Start & Funct3[2];
        req_signed = ~Funct3[0];
        div_zero   = (Rs2 == '0);
        overflow   = req_signed && (Rs1 == MIN_NEG) && (Rs2 == '1);
        abs_rs1    = (req_signed && Rs1[XLEN-1]) ? -Rs1 : Rs1;
        abs_rs2    = (req_signed && Rs2[XLEN-1]) ? -Rs2 : Rs2;
        last_step  = (count_q == CNT_W'(XLEN-1));
        special_result = '0;
        if (div_zero) begin
            special_result = Funct3[1] ? Rs1 : '1;
        end else if (overflow) begin
            special_result = Funct3[1] ? '0 : MIN_NEG;
        end
        if (is_rem_q) begin
            final_result = (r_sign_q && is_signed_q) ? -step_rem : step_rem;
        end else begin
            final_result = (q_sign_q && is_signed_q) ? -step_quo : step_quo;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (div_zero || overflow) ? FIN : CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                if (last_step) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result is written only when entering FIN, so it never glitches between ops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Result      <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            is_signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero || overflow) begin
                            Result <= special_result;
                        end else begin
                            dividend_q  <= abs_rs1;
                            divisor_q   <= abs_rs2;
                            rem_q       <= '0;
                            count_q     <= '0;
                            q_sign_q    <= Rs1[XLEN-1] ^ Rs2[XLEN-1];
                            r_sign_q    <= Rs1[XLEN-1];
                            is_rem_q    <= Funct3[1];
                            is_signed_q <= req_signed;
                        end
                    end
                end
                CALC: begin
                    dividend_q <= step_quo;
                    rem_q      <= step_rem;
                    count_q    <= count_q + CNT_W'(1);
                    if (last_step) begin
                        Result <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
